matmul_sequencer: RTL and testbench

Control sequencer for the matrix-multiply datapath. It accepts a job of operand dimensions R1×C1 and R2×C2 and checks that the dimensions are legal. It then walks i/j/k, issuing row-major read addresses to the two operand buffers, and multiply-accumulates the returned words. Each finished result element is emitted on a valid/ready stream tagged with its row, column and flat address. It replaces the single-shot, fully unrolled multiply with one time-shared MAC that supports runtime dimensions up to MAX_DIM.

---
 rtl/matmul_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//
// Control sequencer for a time-shared matrix-multiply datapath. A job of
// dimensions R1 x C1 times R2 x C2 is validated on start, then the block walks
// i (result row), j (result column) and k (inner index). It issues row-major
// read addresses to the two operand buffers and multiply-accumulates the
// returned words in a single MAC. Every finished result element is offered on
// a valid/ready stream together with its row, column and flat address.
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   start           job request, sampled only while idle
//   R1, C1, R2, C2  job dimensions, sampled together with start
//   busy            high in every state except idle
//   dim_err         one-cycle pulse when a job is rejected
//   done            one-cycle pulse after the last element is accepted
//   rd_en           operand read strobe
//   a_addr, b_addr  operand flat addresses (i*C1+k, k*C2+j)
//   a_data, b_data  operand words, valid one cycle after rd_en
//   res_valid       result element valid
//   res_ready       downstream accept
//   res_data        result element (unsigned sum of products)
//   res_row/res_col i, j of the element
//   res_addr        result flat address i*C2+j
//   dbg_state       current FSM state
//
// Handshake: an element transfers on a rising edge where res_valid and
// res_ready are both high. Once raised, res_valid and the res_* payload hold
// stable until that transfer; only a reset can drop res_valid earlier.
// -----------------------------------------------------------------------------
module matmul_sequencer #(
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 4,
  parameter int ADDR_W  = $clog2(MAX_DIM*MAX_DIM),
  parameter int ACC_W   = 2*DATA_W + $clog2(MAX_DIM)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [3:0]        R1,
  input  logic [3:0]        C1,
  input  logic [3:0]        R2,
  input  logic [3:0]        C2,
  output logic              busy,
  output logic              dim_err,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [3:0]        res_row,
  output logic [3:0]        res_col,
  output logic [ADDR_W-1:0] res_addr,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // R2 is not stored: an accepted job always has R2 == C1.
  logic [3:0]          r_r1;
  logic [3:0]          r_c1;
  logic [3:0]          r_c2;
  logic [3:0]          r_i;
  logic [3:0]          r_j;
  logic [3:0]          r_k;
  logic [ACC_W-1:0]    r_acc;
  logic                r_rd_d;
  logic                r_dim_err;
  logic [ADDR_W-1:0]   r_a_hold;
  logic [ADDR_W-1:0]   r_b_hold;

  logic                w_dims_ok;
  logic                w_k_last;
  logic                w_j_last;
  logic                w_i_last;
  logic                w_hs;
  logic [ADDR_W-1:0]   w_a_addr;
  logic [ADDR_W-1:0]   w_b_addr;
  logic [2*DATA_W-1:0] w_prod;

  // Job legality, evaluated on the live inputs in the cycle start is sampled.
  assign w_dims_ok = (C1 == R2) &&
                     (R1 != 4'd0) && (C1 != 4'd0) && (R2 != 4'd0) && (C2 != 4'd0) &&
                     (R1 <= 4'(MAX_DIM)) && (C1 <= 4'(MAX_DIM)) &&
                     (R2 <= 4'(MAX_DIM)) && (C2 <= 4'(MAX_DIM));

  assign w_k_last = (r_k == r_c1 - 4'd1);
  assign w_j_last = (r_j == r_c2 - 4'd1);
  assign w_i_last = (r_i == r_r1 - 4'd1);

  assign w_a_addr = ADDR_W'(r_i) * ADDR_W'(r_c1) + ADDR_W'(r_k);
  assign w_b_addr = ADDR_W'(r_k) * ADDR_W'(r_c2) + ADDR_W'(r_j);
  assign w_prod   = (2*DATA_W)'(a_data) * (2*DATA_W)'(b_data);

  // Status and stream outputs follow directly from state and counters.
  assign busy      = (r_state != S_IDLE);
  assign rd_en     = (r_state == S_RUN);
  assign res_valid = (r_state == S_EMIT);
  assign done      = (r_state == S_DONE);
  assign dim_err   = r_dim_err;
  assign w_hs      = res_valid && res_ready;

  // Addresses follow i/j/k while reading and freeze at the last issued value.
  assign a_addr    = (r_state == S_RUN) ? w_a_addr : r_a_hold;
  assign b_addr    = (r_state == S_RUN) ? w_b_addr : r_b_hold;

  assign res_data  = r_acc;
  assign res_row   = r_i;
  assign res_col   = r_j;
  assign res_addr  = ADDR_W'(r_i) * ADDR_W'(r_c2) + ADDR_W'(r_j);
  assign dbg_state = r_state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && w_dims_ok) w_next = S_RUN;
      S_RUN:   if (w_k_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_EMIT;
      S_EMIT:  if (w_hs) w_next = (w_i_last && w_j_last) ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_r1      <= '0;
      r_c1      <= '0;
      r_c2      <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_rd_d    <= 1'b0;
      r_dim_err <= 1'b0;
      r_a_hold  <= '0;
      r_b_hold  <= '0;
    end else begin
      r_dim_err <= 1'b0;
      // Marks the cycle in which a_data/b_data carry a requested word.
      r_rd_d    <= rd_en;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_r1 <= R1;
            r_c1 <= C1;
            r_c2 <= C2;
            if (w_dims_ok) begin
              r_i   <= '0;
              r_j   <= '0;
              r_k   <= '0;
              r_acc <= '0;
            end else begin
              r_dim_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_a_hold <= w_a_addr;
          r_b_hold <= w_b_addr;
          r_k      <= w_k_last ? 4'd0 : r_k + 4'd1;
          if (r_rd_d) r_acc <= r_acc + ACC_W'(w_prod);
        end
        S_DRAIN: begin
          // Picks up the product of the last read issued in RUN.
          if (r_rd_d) r_acc <= r_acc + ACC_W'(w_prod);
        end
        S_EMIT: begin
          if (w_hs && !(w_i_last && w_j_last)) begin
            r_acc <= '0;
            if (w_j_last) begin
              r_j <= '0;
              r_i <= r_i + 4'd1;
            end else begin
              r_j <= r_j + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_sequencer
//
// Directed bench for matmul_sequencer. Operand buffers are modelled as two
// small memories answering one cycle after rd_en. Outputs are sampled and
// inputs driven on the falling clock edge. Result elements accepted by the
// bench are collected and compared against hand-computed products held in an
// expected queue.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;

  localparam int DATA_W  = 32;
  localparam int MAX_DIM = 4;
  localparam int ADDR_W  = 4;
  localparam int ACC_W   = 66;

  // clock / reset
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic              start;
  logic [3:0]        R1, C1, R2, C2;
  logic              busy, dim_err, done, rd_en;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              res_valid, res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [3:0]        res_row, res_col;
  logic [ADDR_W-1:0] res_addr;
  logic [2:0]        dbg_state;

  matmul_sequencer #(
    .DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W), .ACC_W(ACC_W)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .R1(R1), .C1(C1), .R2(R2), .C2(C2),
    .busy(busy), .dim_err(dim_err), .done(done), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .res_addr(res_addr),
    .dbg_state(dbg_state)
  );

  // operand buffers: one-cycle read latency, junk when not read
  logic [DATA_W-1:0] a_mem [16];
  logic [DATA_W-1:0] b_mem [16];
  always @(posedge CLK) begin
    if (rd_en) begin
      a_data <= a_mem[a_addr];
      b_data <= b_mem[b_addr];
    end else begin
      a_data <= 32'hDEAD_BEEF;
      b_data <= 32'hDEAD_BEEF;
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0]  exp_q [$];
  logic [ACC_W-1:0]  got_d [$];
  logic [3:0]        got_r [$];
  logic [3:0]        got_c [$];
  logic [ADDR_W-1:0] got_a [$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string t);
    check({t, "_busy"},      busy,      0);
    check({t, "_dim_err"},   dim_err,   0);
    check({t, "_done"},      done,      0);
    check({t, "_rd_en"},     rd_en,     0);
    check({t, "_res_valid"}, res_valid, 0);
    check({t, "_a_addr"},    a_addr,    0);
    check({t, "_b_addr"},    b_addr,    0);
    check({t, "_res_data"},  res_data,  0);
    check({t, "_res_row"},   res_row,   0);
    check({t, "_res_col"},   res_col,   0);
    check({t, "_res_addr"},  res_addr,  0);
    check({t, "_state"},     dbg_state, 0);
  endtask

  // driver: called at a falling edge, returns one cycle later
  task automatic start_job(input logic [3:0] r1, c1, r2, c2);
    R1 = r1; C1 = c1; R2 = r2; C2 = c2;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Runs from the first RUN cycle until done; cycle 0 is the first RUN cycle.
  // Each element is held off for 'stall' cycles before being accepted.
  task automatic collect(input int stall, input int max_cyc,
                         output int done_cyc, output int rd_cnt);
    int cyc = 0;
    int stall_left = 0;
    bit in_elem = 1'b0;
    logic [ACC_W-1:0]  snap_d = '0;
    logic [3:0]        snap_r = '0;
    logic [3:0]        snap_c = '0;
    logic [ADDR_W-1:0] snap_a = '0;
    done_cyc  = -1;
    rd_cnt    = 0;
    res_ready = (stall == 0);
    while (cyc < max_cyc) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (rd_en) rd_cnt++;
      if (res_valid) begin
        if (!in_elem) begin
          in_elem = 1'b1;
          stall_left = stall;
          snap_d = res_data; snap_r = res_row; snap_c = res_col; snap_a = res_addr;
        end else begin
          check("hold_data", res_data, snap_d);
          check("hold_row",  res_row,  snap_r);
          check("hold_col",  res_col,  snap_c);
          check("hold_addr", res_addr, snap_a);
          check("hold_no_rd", rd_en, 0);
        end
        if (stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
        end else begin
          res_ready = 1'b1;
          got_d.push_back(res_data);
          got_r.push_back(res_row);
          got_c.push_back(res_col);
          got_a.push_back(res_addr);
          in_elem = 1'b0;
        end
      end else if (in_elem) begin
        check("valid_dropped", res_valid, 1);
        in_elem = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    if (done_cyc < 0) check("done_timeout", done, 1);
  endtask

  task automatic compare_results(input string t, input int c2);
    check({t, "_count"}, got_d.size(), exp_q.size());
    for (int n = 0; n < exp_q.size(); n++) begin
      check($sformatf("%s_data%0d", t, n), got_d[n], exp_q[n]);
      check($sformatf("%s_row%0d",  t, n), got_r[n], n / c2);
      check($sformatf("%s_col%0d",  t, n), got_c[n], n % c2);
      check($sformatf("%s_addr%0d", t, n), got_a[n], n);
    end
    got_d.delete(); got_r.delete(); got_c.delete(); got_a.delete();
    exp_q.delete();
  endtask

  task automatic load_2x2;
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
    b_mem[0] = 5; b_mem[1] = 6; b_mem[2] = 7; b_mem[3] = 8;
  endtask

  task automatic expect_2x2;
    exp_q.push_back(66'd19);
    exp_q.push_back(66'd22);
    exp_q.push_back(66'd43);
    exp_q.push_back(66'd50);
  endtask

  // hard time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, rc;
    start = 1'b0; R1 = '0; C1 = '0; R2 = '0; C2 = '0; res_ready = 1'b0;
    for (int n = 0; n < 16; n++) begin
      a_mem[n] = '0;
      b_mem[n] = '0;
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset("rst0");
    RST = 1'b0;
    @(negedge CLK);

    // 2x2 * 2x2, res_ready high
    load_2x2();
    start_job(4'd2, 4'd2, 4'd2, 4'd2);
    // dimension changes while busy must be ignored
    C1 = 4'd3; C2 = 4'd1;
    check("s1_busy",   busy,   1);
    check("s1_rd_en",  rd_en,  1);
    check("s1_a_addr", a_addr, 0);
    check("s1_b_addr", b_addr, 0);
    collect(0, 200, dc, rc);
    // done lands R1*C2*(C1+2) cycles after the first RUN cycle (17 inclusive)
    check("s1_done_cyc", dc, 16);
    check("s1_rd_cnt",   rc, 8);
    expect_2x2();
    compare_results("s1", 2);
    // start raised during the done cycle is ignored
    start_job(4'd2, 4'd2, 4'd2, 4'd2);
    check("s1_done_pulse", done,  0);
    check("s1_ign_busy",   busy,  0);
    check("s1_ign_rd_en",  rd_en, 0);

    // 1x3 * 3x1
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3;
    b_mem[0] = 4; b_mem[1] = 5; b_mem[2] = 6;
    start_job(4'd1, 4'd3, 4'd3, 4'd1);
    collect(0, 100, dc, rc);
    check("s2_done_cyc", dc, 5);
    check("s2_rd_cnt",   rc, 3);
    exp_q.push_back(66'd32);
    compare_results("s2", 1);
    @(negedge CLK);

    // 1x1 * 1x1
    a_mem[0] = 7; b_mem[0] = 9;
    start_job(4'd1, 4'd1, 4'd1, 4'd1);
    collect(0, 100, dc, rc);
    check("s3_done_cyc", dc, 3);
    exp_q.push_back(66'd63);
    compare_results("s3", 1);
    @(negedge CLK);

    // rejected jobs: C1 != R2, zero dimension, dimension above MAX_DIM
    start_job(4'd2, 4'd3, 4'd2, 4'd2);
    check("e1_dim_err", dim_err, 1);
    check("e1_busy",    busy,    0);
    check("e1_rd_en",   rd_en,   0);
    @(negedge CLK);
    check("e1_pulse",   dim_err, 0);
    check("e1_busy2",   busy,    0);
    check("e1_valid",   res_valid, 0);
    start_job(4'd0, 4'd2, 4'd2, 4'd2);
    check("e2_dim_err", dim_err, 1);
    check("e2_busy",    busy,    0);
    @(negedge CLK);
    check("e2_pulse",   dim_err, 0);
    check("e2_rd_en",   rd_en,   0);
    start_job(4'd2, 4'd2, 4'd2, 4'd5);
    check("e3_dim_err", dim_err, 1);
    check("e3_busy",    busy,    0);
    @(negedge CLK);
    check("e3_pulse",   dim_err, 0);
    check("e3_rd_en",   rd_en,   0);
    check("e3_valid",   res_valid, 0);

    // 2x2 with every element stalled 3 cycles
    load_2x2();
    start_job(4'd2, 4'd2, 4'd2, 4'd2);
    collect(3, 300, dc, rc);
    check("s4_done_cyc", dc, 28);
    check("s4_rd_cnt",   rc, 8);
    expect_2x2();
    compare_results("s4", 2);
    @(negedge CLK);

    // 4x4 * 4x4 of all-ones words: 4*(2^32-1)^2 per element
    for (int n = 0; n < 16; n++) begin
      a_mem[n] = 32'hFFFF_FFFF;
      b_mem[n] = 32'hFFFF_FFFF;
    end
    start_job(4'd4, 4'd4, 4'd4, 4'd4);
    collect(0, 300, dc, rc);
    check("s5_done_cyc", dc, 96);
    check("s5_rd_cnt",   rc, 64);
    for (int n = 0; n < 16; n++) exp_q.push_back(66'h3_FFFF_FFF8_0000_0004);
    compare_results("s5", 4);
    @(negedge CLK);

    // reset during RUN of element (0,1), then a clean rerun
    load_2x2();
    start_job(4'd2, 4'd2, 4'd2, 4'd2);
    repeat (4) @(negedge CLK);
    check("s6_in_run", rd_en,   1);
    check("s6_col",    res_col, 1);
    RST = 1'b1;
    @(negedge CLK);
    check_reset("rst_mid");
    RST = 1'b0;
    start_job(4'd2, 4'd2, 4'd2, 4'd2);
    collect(0, 200, dc, rc);
    check("s6_done_cyc", dc, 16);
    expect_2x2();
    compare_results("s6", 2);
    @(negedge CLK);
    check("s6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
